// File: rtl/registers_bank_mp_if.sv
// Bus interface for the multi-port register file. It carries the write ports,
// the read ports, the issue/scoreboard port and the conflict flag.
// The master modport belongs to the pipeline that drives the bank, and the slave
// modport belongs to the register file.
interface registers_bank_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);
  // Write port A (ALU writeback)
  logic                             we_a;
  logic [ADDR_WIDTH-1:0]            sel_in_a;
  logic [DATA_WIDTH-1:0]            data_in_a;
  // Write port B (load / late writeback)
  logic                             we_b;
  logic [ADDR_WIDTH-1:0]            sel_in_b;
  logic [DATA_WIDTH-1:0]            data_in_b;
  // Read ports, packed with port i at slice i
  logic [NUM_READ*ADDR_WIDTH-1:0]   sel_out;
  logic [NUM_READ*DATA_WIDTH-1:0]   data_out;
  logic [NUM_READ-1:0]              busy_out;
  // Scoreboard issue port
  logic                             issue_valid;
  logic [ADDR_WIDTH-1:0]            issue_sel;
  // Same-index dual-write indicator
  logic                             write_conflict;

  modport master (
    output we_a, sel_in_a, data_in_a,
    output we_b, sel_in_b, data_in_b,
    output sel_out,
    input  data_out, busy_out,
    output issue_valid, issue_sel,
    input  write_conflict
  );

  modport slave (
    input  we_a, sel_in_a, data_in_a,
    input  we_b, sel_in_b, data_in_b,
    input  sel_out,
    output data_out, busy_out,
    input  issue_valid, issue_sel,
    output write_conflict
  );
endinterface

// File: rtl/registers_bank_mp.sv
// Multi-port integer register file with a per-register busy scoreboard.
// It has NUM_READ combinational read ports and two write ports.
// When A and B write the same index, B wins and a conflict flag is raised for one cycle.
// The optional macro REGFILE_BYPASS_EN forwards same-cycle write data and busy
// clears to the read ports. Without it, reads only see the stored state.
module registers_bank_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  registers_bank_mp_if.slave    rf
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // True when idx names the hardwired zero register
  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  logic [DATA_WIDTH-1:0]          mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]          mem_d [DEPTH];
  logic [DEPTH-1:0]               busy_q;
  logic [DEPTH-1:0]               busy_d;
  logic                           write_conflict_q;
  logic                           write_conflict_d;

  logic                           wr_a_en;
  logic                           wr_b_en;
  logic                           same_idx;
  logic                           issue_ok;

  logic [NUM_READ*DATA_WIDTH-1:0] data_out_w;
  logic [NUM_READ-1:0]            busy_out_w;
  logic [ADDR_WIDTH-1:0]          rd_idx;

  // Qualify write/issue requests (index 0 is inert when hardwired to zero)
  always_comb begin
    wr_a_en  = rf.we_a && !is_zero_reg(rf.sel_in_a);
    wr_b_en  = rf.we_b && !is_zero_reg(rf.sel_in_b);
    same_idx = (rf.sel_in_a == rf.sel_in_b);
    issue_ok = rf.issue_valid && !is_zero_reg(rf.issue_sel);
  end

  // Next array contents: port A is dropped when port B targets the same index
  always_comb begin
    mem_d = mem_q;
    if (wr_a_en && !(wr_b_en && same_idx)) begin
      mem_d[rf.sel_in_a] = rf.data_in_a;
    end
    if (wr_b_en) begin
      mem_d[rf.sel_in_b] = rf.data_in_b;
    end
  end

  // Next scoreboard: writebacks clear, a new issue sets and wins over a clear
  always_comb begin
    busy_d = busy_q;
    if (wr_a_en) begin
      busy_d[rf.sel_in_a] = 1'b0;
    end
    if (wr_b_en) begin
      busy_d[rf.sel_in_b] = 1'b0;
    end
    if (issue_ok) begin
      busy_d[rf.issue_sel] = 1'b1;
    end
  end

  // Conflict flag for the cycle after a same-index dual write
  always_comb begin
    write_conflict_d = wr_a_en && wr_b_en && same_idx;
  end

  // State registers, cleared immediately by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
      busy_q           <= '0;
      write_conflict_q <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= mem_d[r];
      end
      busy_q           <= busy_d;
      write_conflict_q <= write_conflict_d;
    end
  end

  // Combinational read ports with optional same-cycle write forwarding
  always_comb begin
    data_out_w = '0;
    busy_out_w = '0;
    rd_idx     = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      rd_idx = rf.sel_out[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (is_zero_reg(rd_idx)) begin
        data_out_w[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        busy_out_w[i]                          = 1'b0;
      end else begin
        data_out_w[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_idx];
        busy_out_w[i]                          = busy_q[rd_idx];
`ifdef REGFILE_BYPASS_EN
        if (wr_b_en && (rf.sel_in_b == rd_idx)) begin
          data_out_w[i*DATA_WIDTH +: DATA_WIDTH] = rf.data_in_b;
          busy_out_w[i] = issue_ok && (rf.issue_sel == rd_idx);
        end else if (wr_a_en && (rf.sel_in_a == rd_idx)) begin
          data_out_w[i*DATA_WIDTH +: DATA_WIDTH] = rf.data_in_a;
          busy_out_w[i] = issue_ok && (rf.issue_sel == rd_idx);
        end
`else
        // Stored state only; new data and busy clears appear after the edge
`endif
      end
    end
  end

  assign rf.data_out       = data_out_w;
  assign rf.busy_out       = busy_out_w;
  assign rf.write_conflict = write_conflict_q;

endmodule
